// File: rtl/core_issue_ctrl_pkg.sv
// Shared types for the issue controller: decode record, register numbering, mul FSM states.
package core_issue_ctrl_pkg;

    localparam int NUM_REGS_DEF   = 16;
    localparam int MUL_CYCLES_DEF = 4;
    localparam int REG_W          = $clog2(NUM_REGS_DEF);

    typedef logic [REG_W-1:0]        reg_num;
    typedef logic [NUM_REGS_DEF-1:0] reg_mask;

    typedef enum logic [0:0] {MUL_IDLE = 1'b0, MUL_BUSY = 1'b1} mul_state;

    typedef struct packed {
        logic execute;
        logic mul;
        logic writeback;
        logic uses_ra;
        logic uses_rb;
    } insn_ctrl;

    typedef struct packed {
        reg_num rd;
        reg_num ra;
        reg_num rb;
    } insn_data;

    typedef struct packed {
        insn_ctrl    ctrl;
        insn_data    data;
        logic [31:0] pc;
    } insn_decode;

endpackage

// File: rtl/core_issue_mul_timer.sv
// Multiplier occupancy timer: IDLE/BUSY FSM with a down-counter; mul_done marks the last busy cycle.
module core_issue_mul_timer
    import core_issue_ctrl_pkg::*;
#(
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic mul_busy,
    output logic mul_done
);

    localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    mul_state         state;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= MUL_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MUL_IDLE: if (start) begin
                    state <= MUL_BUSY;
                    cnt   <= CNT_W'(MUL_CYCLES - 1);
                end
                MUL_BUSY: begin
                    if (cnt == '0) state <= MUL_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= MUL_IDLE;
            endcase
        end
    end

    assign mul_busy = (state == MUL_BUSY);
    assign mul_done = mul_busy && (cnt == '0);

endmodule

// File: rtl/core_issue_ctrl.sv
// Issue controller: register scoreboard, hazard/stall/issue logic, branch flush, mul sequencing.
// Optional CORE_ISSUE_WB_BYPASS_EN lets a reader issue in the same cycle its producer writes back.
module core_issue_ctrl
    import core_issue_ctrl_pkg::*;
#(
    parameter int NUM_REGS   = NUM_REGS_DEF,
    parameter int MUL_CYCLES = MUL_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  insn_decode dec,
    input  logic       ex_stall,
    input  logic       branch_taken,
    input  logic       wb_valid,
    input  reg_num     wb_rd,
    output logic       stall,
    output logic       flush,
    output logic       issue,
    output logic       mul_busy,
    output logic       mul_done
);

    logic [NUM_REGS-1:0] pend, pend_chk, wb_mask, set_mask;
    logic                hazard;
    logic                unused_pc;
    insn_ctrl            c;

    assign c         = dec.ctrl;
    assign unused_pc = ^dec.pc;
    assign wb_mask   = wb_valid ? (NUM_REGS'(1) << wb_rd) : '0;

`ifdef CORE_ISSUE_WB_BYPASS_EN
    // Regfile is write-through, so a register being written this cycle is already readable.
    assign pend_chk = pend & ~wb_mask;
`else
    assign pend_chk = pend;
`endif

    assign hazard = (c.uses_ra   & pend_chk[dec.data.ra])
                  | (c.uses_rb   & pend_chk[dec.data.rb])
                  | (c.writeback & pend_chk[dec.data.rd])
                  | (c.mul       & mul_busy);

    assign flush = branch_taken;
    assign stall = c.execute & (hazard | ex_stall) & ~flush;
    assign issue = c.execute & ~hazard & ~ex_stall & ~flush;

    assign set_mask = (issue & c.writeback) ? (NUM_REGS'(1) << dec.data.rd) : '0;

    // Set is applied after clear: the issuing insn is younger than the one writing back.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else        pend <= ((pend & ~wb_mask) | set_mask) & ~NUM_REGS'(1);
    end

    core_issue_mul_timer #(.MUL_CYCLES(MUL_CYCLES)) u_mul (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (issue & c.mul),
        .mul_busy (mul_busy),
        .mul_done (mul_done)
    );

endmodule
